// File: rtl/drainmem_if.sv
// Handshake bundle for drainmem: the 32-bit output word stream and the DDR
// read-request / read-return channel. The master side is the drain stage.
`ifndef MEM_ADDRBITS
`define MEM_ADDRBITS 20
`endif

interface drainmem_if #(
  parameter int ADDR_BITS = `MEM_ADDRBITS
);
  logic [31:0]          o_outdata;
  logic                 o_outdata_have;
  logic                 i_outdata_want;
  logic [ADDR_BITS-1:0] o_ddr_raddr;
  logic                 o_ddr_rreq;
  logic                 i_ddr_rreq_accept;
  logic [127:0]         i_ddr_rdata;
  logic                 i_ddr_rdata_valid;

  modport master (
    output o_outdata, o_outdata_have, o_ddr_raddr, o_ddr_rreq,
    input  i_outdata_want, i_ddr_rreq_accept, i_ddr_rdata, i_ddr_rdata_valid
  );

  modport slave (
    input  o_outdata, o_outdata_have, o_ddr_raddr, o_ddr_rreq,
    output i_outdata_want, i_ddr_rreq_accept, i_ddr_rdata, i_ddr_rdata_valid
  );
endinterface

// File: rtl/drainmem.sv
// Reads one problem's adjacency bit-matrix back from DDR as 128-bit lines and
// streams it out as 32-bit words. Requests are credit-limited against a
// 4-line buffer so returned lines, which cannot be stalled, always fit.
//
// state | meaning
// IDLE  | waiting for i_go; sizes, base address and buffer held in reset
// RUN   | issuing line reads and draining words to the consumer
// DONE  | one-cycle o_done pulse, then back to IDLE
`ifndef MAX_VERTSBITS
`define MAX_VERTSBITS 8
`endif
`ifndef MAX_PROBSBITS
`define MAX_PROBSBITS 8
`endif
`ifndef MEM_ADDRBITS
`define MEM_ADDRBITS 20
`endif
`ifndef MEM_PROBSBITS
`define MEM_PROBSBITS 4
`endif

module drainmem #(
  parameter int VERTS_BITS = `MAX_VERTSBITS,
  parameter int PROBS_BITS = `MAX_PROBSBITS,
  parameter int ADDR_BITS  = `MEM_ADDRBITS,
  parameter int APROB_BITS = `MEM_PROBSBITS
) (
  input  logic                  i_clk150,
  input  logic                  i_reset_n,
  input  logic                  i_go,
  input  logic [PROBS_BITS-1:0] i_prob_no,
  input  logic [VERTS_BITS-1:0] i_nverts,
  output logic                  o_done,
  drainmem_if.master            bus
);
  localparam int CW = 2 * VERTS_BITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]        nverts_sq, nwords_in, nlines_in;
  logic [CW-1:0]        nwords, nlines, req_cnt, word_cnt;
  logic [ADDR_BITS-1:0] addr;
  logic [1:0]           k, wr_ptr, rd_ptr;
  logic [2:0]           outstanding, count;
  logic [127:0]         mem [4];
  logic                 rreq, req_fire, push, pop, xfer, have, last_word;
  logic                 unused_prob;

  // Word and line counts rounded up; no wrap since the square fits in CW bits
  assign nverts_sq = CW'(i_nverts) * CW'(i_nverts);
  assign nwords_in = (nverts_sq >> 5) + CW'(|nverts_sq[4:0]);
  assign nlines_in = (nwords_in >> 2) + CW'(|nwords_in[1:0]);
  assign unused_prob = ^i_prob_no;

  assign last_word = (word_cnt == nwords - CW'(1));
  assign req_fire  = rreq && bus.i_ddr_rreq_accept;

  assign bus.o_ddr_rreq     = rreq;
  assign bus.o_ddr_raddr    = addr;
  assign bus.o_outdata_have = have;
  assign bus.o_outdata      = mem[rd_ptr][{k, 5'd0} +: 32];

  // State register
  always_ff @(posedge i_clk150 or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  // Next state, request credit, buffer push/pop and transfer decode
  always_comb begin
    state_nx = state;
    o_done   = 1'b0;
    rreq     = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    xfer     = 1'b0;
    have     = 1'b0;
    case (state)
      IDLE: begin
        if (i_go) state_nx = (nwords_in == '0) ? DONE : RUN;
      end
      RUN: begin
        rreq = (req_cnt < nlines) && (({1'b0, outstanding} + {1'b0, count}) < 4'd4);
        push = bus.i_ddr_rdata_valid;
        have = (count != 3'd0);
        xfer = have && bus.i_outdata_want;
        pop  = xfer && ((k == 2'd3) || last_word);
        if (xfer && last_word) state_nx = DONE;
      end
      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters, address and line buffer; IDLE keeps everything loaded/cleared
  always_ff @(posedge i_clk150 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      nwords      <= '0;
      nlines      <= '0;
      addr        <= '0;
      req_cnt     <= '0;
      word_cnt    <= '0;
      k           <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      count       <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (state == IDLE) begin
      nwords      <= nwords_in;
      nlines      <= nlines_in;
      addr        <= {i_prob_no[APROB_BITS-1:0], {(ADDR_BITS-APROB_BITS){1'b0}}};
      req_cnt     <= '0;
      word_cnt    <= '0;
      k           <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      count       <= '0;
    end else if (state == RUN) begin
      if (req_fire) begin
        addr    <= addr + ADDR_BITS'(1);
        req_cnt <= req_cnt + CW'(1);
      end
      case ({req_fire, push})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
      if (push) begin
        mem[wr_ptr] <= bus.i_ddr_rdata;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (xfer) begin
        word_cnt <= word_cnt + CW'(1);
        k        <= k + 2'd1;
      end
    end
  end

  // The credit rule must keep a returned line from ever meeting a full buffer
  a_no_overflow: assert property (@(posedge i_clk150) disable iff (!i_reset_n)
    !(push && (count == 3'd4)));

endmodule

// File: tb/tb_drainmem.sv
// Directed bench for drainmem: a DDR responder with optional random accept
// and return delays, a word collector, and a linear sequence of scenarios.
module tb_drainmem;
  localparam int VB  = 8;
  localparam int PB  = 8;
  localparam int AB  = 20;
  localparam int APB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic [PB-1:0] prob;
  logic [VB-1:0] nverts;
  logic          done;

  drainmem_if #(.ADDR_BITS(AB)) dif ();

  drainmem #(
    .VERTS_BITS(VB), .PROBS_BITS(PB), .ADDR_BITS(AB), .APROB_BITS(APB)
  ) dut (
    .i_clk150  (clk),
    .i_reset_n (rst_n),
    .i_go      (go),
    .i_prob_no (prob),
    .i_nverts  (nverts),
    .o_done    (done),
    .bus       (dif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int done_cnt, done_cyc, last_xfer_cyc, rreq_cnt, issued, popped, max_inflight;
  int acc_wait;
  int exp_nwords;
  bit rand_mode, want_block;
  int run_id = 0;
  int seen_id = 0;

  logic [31:0]   got[$];
  logic [AB-1:0] req_addrs[$];
  logic [AB-1:0] pend_addr[$];
  int            pend_rdy[$];

  function automatic logic [31:0] exp_word(input logic [AB-1:0] base, input int w);
    logic [AB-1:0] a;
    a = base + AB'(w / 4);
    return {4'hD, 2'b00, 2'(w % 4), 4'h0, a};
  endfunction

  function automatic logic [127:0] line_of(input logic [AB-1:0] a);
    logic [127:0] l;
    for (int j = 0; j < 4; j++) l[32*j +: 32] = {4'hD, 2'b00, 2'(j), 4'h0, a};
    return l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // DDR responder and output collector, all decisions taken at the falling edge
  initial begin
    bit want_now;
    int w;
    dif.i_outdata_want    = 1'b0;
    dif.i_ddr_rreq_accept = 1'b0;
    dif.i_ddr_rdata_valid = 1'b0;
    dif.i_ddr_rdata       = '0;
    acc_wait = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (run_id != seen_id) begin
        seen_id = run_id;
        got.delete(); req_addrs.delete();
        done_cnt = 0; done_cyc = 0; last_xfer_cyc = 0; rreq_cnt = 0;
        issued = 0; popped = 0; max_inflight = 0;
      end
      if (!rst_n) begin
        pend_addr.delete(); pend_rdy.delete();
        dif.i_outdata_want    = 1'b0;
        dif.i_ddr_rreq_accept = 1'b0;
        dif.i_ddr_rdata_valid = 1'b0;
        acc_wait = 0;
      end else begin
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (dif.o_ddr_rreq) rreq_cnt++;
        want_now = want_block ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        dif.i_outdata_want = want_now;
        if (dif.o_outdata_have && want_now) begin
          w = got.size();
          got.push_back(dif.o_outdata);
          last_xfer_cyc = cyc;
          if ((w % 4 == 3) || (w == exp_nwords - 1)) popped++;
        end
        dif.i_ddr_rreq_accept = 1'b0;
        if (dif.o_ddr_rreq) begin
          if (acc_wait == 0) begin
            dif.i_ddr_rreq_accept = 1'b1;
            req_addrs.push_back(dif.o_ddr_raddr);
            pend_addr.push_back(dif.o_ddr_raddr);
            pend_rdy.push_back(cyc + 1 + (rand_mode ? int'($urandom_range(0, 7)) : 0));
            issued++;
            acc_wait = rand_mode ? int'($urandom_range(0, 7)) : 0;
          end else begin
            acc_wait--;
          end
        end
        dif.i_ddr_rdata_valid = 1'b0;
        if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
          dif.i_ddr_rdata_valid = 1'b1;
          dif.i_ddr_rdata       = line_of(pend_addr.pop_front());
          void'(pend_rdy.pop_front());
        end
        if (issued - popped > max_inflight) max_inflight = issued - popped;
      end
    end
  end

  task automatic start_run(input int nv, input int pb, input bit rnd, input int words);
    rand_mode  = rnd;
    exp_nwords = words;
    run_id++;
    @(negedge clk); #1;
    nverts = VB'(nv);
    prob   = PB'(pb);
    go     = 1'b1;
    @(negedge clk); #1;
    go = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int words, input int lines,
                            input logic [AB-1:0] base);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin @(negedge clk); #1; n++; end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_nwords"}, 64'(got.size()), 64'(words));
    for (int w = 0; w < words && w < got.size(); w++)
      chk({tag, "_word"}, 64'(got[w]), 64'(exp_word(base, w)));
    chk({tag, "_nreq"}, 64'(req_addrs.size()), 64'(lines));
    for (int i = 0; i < lines && i < req_addrs.size(); i++)
      chk({tag, "_raddr"}, 64'(req_addrs[i]), 64'(base + AB'(i)));
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_timing"}, 64'(done_cyc - last_xfer_cyc), 64'd1);
    chk({tag, "_inflight_le4"}, 64'(max_inflight <= 4), 64'd1);
    chk({tag, "_have_idle"}, 64'(dif.o_outdata_have), 64'd0);
  endtask

  // Directed scenarios
  initial begin
    int n;
    rst_n = 1'b0; go = 1'b0; prob = '0; nverts = '0;
    want_block = 1'b0; rand_mode = 1'b0; exp_nwords = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done",    64'(done), 64'd0);
    chk("rst_have",    64'(dif.o_outdata_have), 64'd0);
    chk("rst_rreq",    64'(dif.o_ddr_rreq), 64'd0);
    chk("rst_outdata", 64'(dif.o_outdata), 64'd0);
    chk("rst_raddr",   64'(dif.o_ddr_raddr), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    start_run(8, 0, 1'b0, 2);
    chk("small_first_rreq",  64'(dif.o_ddr_rreq), 64'd1);
    chk("small_first_raddr", 64'(dif.o_ddr_raddr), 64'd0);
    finish_run("small", 2, 1, 20'h00000);
    chk("small_w0", 64'(got[0]), 64'hD000_0000);
    chk("small_w1", 64'(got[1]), 64'hD100_0000);

    start_run(16, 3, 1'b0, 8);
    finish_run("two", 8, 2, 20'h30000);
    chk("two_w5", 64'(got[5]), 64'hD103_0001);

    start_run(0, 0, 1'b0, 0);
    chk("zero_done",      64'(done), 64'd1);
    chk("zero_rreq",      64'(dif.o_ddr_rreq), 64'd0);
    @(negedge clk); #1;
    chk("zero_done_low",  64'(done), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("zero_rreq_cnt",  64'(rreq_cnt), 64'd0);
    chk("zero_done_cnt",  64'(done_cnt), 64'd1);

    start_run(10, 2, 1'b0, 4);
    finish_run("p10", 4, 1, 20'h20000);
    start_run(12, 1, 1'b0, 5);
    finish_run("p12", 5, 2, 20'h10000);

    want_block = 1'b1;
    start_run(64, 7, 1'b0, 128);
    repeat (10) @(negedge clk);
    #1; go = 1'b1; nverts = '0;
    @(negedge clk); #1; go = 1'b0; nverts = 8'd64;
    repeat (40) @(negedge clk);
    #1;
    chk("bp_issued",   64'(issued), 64'd4);
    chk("bp_inflight", 64'(max_inflight <= 4), 64'd1);
    chk("bp_no_out",   64'(got.size()), 64'd0);
    chk("bp_no_done",  64'(done_cnt), 64'd0);
    chk("bp_have",     64'(dif.o_outdata_have), 64'd1);
    want_block = 1'b0;
    finish_run("bp", 128, 32, 20'h70000);

    start_run(64, 1, 1'b0, 128);
    n = 0;
    while (got.size() < 10 && n < 1000) begin @(negedge clk); #1; n++; end
    chk("rstmid_reach10", 64'(got.size() >= 10), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_done",    64'(done), 64'd0);
    chk("rstmid_have",    64'(dif.o_outdata_have), 64'd0);
    chk("rstmid_rreq",    64'(dif.o_ddr_rreq), 64'd0);
    chk("rstmid_outdata", 64'(dif.o_outdata), 64'd0);
    chk("rstmid_raddr",   64'(dif.o_ddr_raddr), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rstmid_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    start_run(64, 5, 1'b1, 128);
    finish_run("rand64", 128, 32, 20'h50000);
    start_run(16, 9, 1'b1, 8);
    finish_run("rand16", 8, 2, 20'h90000);
    start_run(12, 4, 1'b1, 5);
    finish_run("rand12", 5, 2, 20'h40000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d tests expected completion", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
